// File: rtl/rx_frame_sequencer.sv
// Drains the RX bridge read window: copies each queued frame into a packet-RAM
// slot (or discards it) and emits a one-cycle completion record plus IRQ.
module rx_frame_sequencer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_BUFS   = 4,
  parameter  int BUF_BYTES  = 2048,
  localparam int MM_BYTES   = DATA_WIDTH/8,
  localparam int WPS        = BUF_BYTES/MM_BYTES,
  localparam int WADDR_W    = $clog2(NUM_BUFS*WPS),
  localparam int SLOT_W     = $clog2(NUM_BUFS)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  drop_bad_en,
  input  logic                  drop_when_full,
  input  logic                  rx_frame_ready,
  input  logic [15:0]           rx_len,
  input  logic                  rx_bad_fcs,
  input  logic [DATA_WIDTH-1:0] rxw_data,
  input  logic                  rxw_valid,
  output logic                  rxw_pop,
  output logic                  mem_wr_en,
  output logic [WADDR_W-1:0]    mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_ready,
  input  logic                  buf_release,
  output logic                  cpl_valid,
  output logic [SLOT_W-1:0]     cpl_slot,
  output logic [15:0]           cpl_len,
  output logic [2:0]            cpl_flags,
  output logic                  irq,
  output logic [SLOT_W:0]       free_slots,
  output logic [15:0]           cnt_ok,
  output logic [15:0]           cnt_drop_bad,
  output logic [15:0]           cnt_drop_full,
  output logic                  err
);
  localparam int WIDX_W = $clog2(WPS);
  localparam int MB_W   = $clog2(MM_BYTES);
  localparam logic [SLOT_W:0] FREE_ALL = (SLOT_W+1)'(NUM_BUFS);
  localparam logic [SLOT_W:0] FREE_ONE = (SLOT_W+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COPY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [SLOT_W-1:0] r_wr_slot;
  logic [SLOT_W:0]   r_free;
  logic [15:0]       r_len;
  logic              r_bad, r_dropped, r_drop_bad, r_trunc, r_err;
  logic [16:0]       r_nwords, r_word_idx;
  logic [15:0]       r_cnt_ok, r_cnt_drop_bad, r_cnt_drop_full;

  logic        w_in_win, w_wr, w_pop, w_last, w_rel_ok, w_take;
  logic        w_bad_drop, w_full;
  logic [16:0] w_nwords;

  assign w_nwords   = (17'(rx_len) + 17'(MM_BYTES-1)) >> MB_W;
  assign w_in_win   = 32'(r_word_idx) < WPS;
  assign w_last     = r_word_idx == r_nwords - 17'd1;
  assign w_bad_drop = rx_bad_fcs && drop_bad_en;
  assign w_full     = r_free == '0;
  assign w_rel_ok   = buf_release && (r_free != FREE_ALL);
  assign w_take     = (r_state == S_DONE) && !r_dropped;

  // Words past the slot boundary are still consumed so the bridge drains.
  always_comb begin
    w_wr  = 1'b0;
    w_pop = 1'b0;
    case (r_state)
      S_COPY: begin
        w_wr  = rxw_valid && mem_wr_ready && w_in_win;
        w_pop = w_in_win ? w_wr : rxw_valid;
      end
      S_DRAIN: w_pop = rxw_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_wr_slot       <= '0;
      r_free          <= FREE_ALL;
      r_len           <= '0;
      r_bad           <= 1'b0;
      r_dropped       <= 1'b0;
      r_drop_bad      <= 1'b0;
      r_trunc         <= 1'b0;
      r_err           <= 1'b0;
      r_nwords        <= '0;
      r_word_idx      <= '0;
      r_cnt_ok        <= '0;
      r_cnt_drop_bad  <= '0;
      r_cnt_drop_full <= '0;
    end else begin
      // Release and a copy completion in the same cycle cancel out.
      case ({w_rel_ok, w_take})
        2'b10:   r_free <= r_free + FREE_ONE;
        2'b01:   r_free <= r_free - FREE_ONE;
        default: ;
      endcase
      if (buf_release && !w_rel_ok) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (rx_frame_ready && rx_len == 16'd0) begin
            r_err <= 1'b1;
          end else if (enable && rx_frame_ready &&
                       (w_bad_drop || !w_full || drop_when_full)) begin
            r_len      <= rx_len;
            r_bad      <= rx_bad_fcs;
            r_nwords   <= w_nwords;
            r_word_idx <= '0;
            r_trunc    <= 1'b0;
            r_dropped  <= w_bad_drop || w_full;
            r_drop_bad <= w_bad_drop;
            r_state    <= (w_bad_drop || w_full) ? S_DRAIN : S_COPY;
          end
        end
        S_COPY, S_DRAIN: begin
          if (w_pop) begin
            r_word_idx <= r_word_idx + 17'd1;
            if (r_state == S_COPY && !w_in_win) r_trunc <= 1'b1;
            if (w_last) r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          if (!r_dropped) begin
            r_wr_slot <= r_wr_slot + SLOT_W'(1);
            if (r_cnt_ok != 16'hFFFF) r_cnt_ok <= r_cnt_ok + 16'd1;
          end else if (r_drop_bad) begin
            if (r_cnt_drop_bad != 16'hFFFF) r_cnt_drop_bad <= r_cnt_drop_bad + 16'd1;
          end else begin
            if (r_cnt_drop_full != 16'hFFFF) r_cnt_drop_full <= r_cnt_drop_full + 16'd1;
          end
        end
      endcase
    end
  end

  assign rxw_pop       = w_pop;
  assign mem_wr_en     = w_wr;
  assign mem_wr_addr   = {r_wr_slot, r_word_idx[WIDX_W-1:0]};
  assign mem_wr_data   = rxw_data;
  assign cpl_valid     = r_state == S_DONE;
  assign irq           = cpl_valid;
  assign cpl_slot      = (cpl_valid && !r_dropped) ? r_wr_slot : '0;
  assign cpl_len       = cpl_valid ? r_len : 16'd0;
  assign cpl_flags     = cpl_valid ? {r_dropped, r_trunc, r_bad} : 3'b000;
  assign free_slots    = r_free;
  assign cnt_ok        = r_cnt_ok;
  assign cnt_drop_bad  = r_cnt_drop_bad;
  assign cnt_drop_full = r_cnt_drop_full;
  assign err           = r_err;
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed bench: a small bridge model feeds frames, a monitor logs RAM writes,
// pops and completions, and a vector table plus corner sequences check them.
module tb_rx_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst, enable, drop_bad_en, drop_when_full;
  logic        rx_frame_ready, rx_bad_fcs, rxw_valid, rxw_pop;
  logic [15:0] rx_len;
  logic [31:0] rxw_data, mem_wr_data;
  logic        mem_wr_en, mem_wr_ready, buf_release;
  logic [10:0] mem_wr_addr;
  logic        cpl_valid, irq, err;
  logic [1:0]  cpl_slot;
  logic [15:0] cpl_len;
  logic [2:0]  cpl_flags;
  logic [2:0]  free_slots;
  logic [15:0] cnt_ok, cnt_drop_bad, cnt_drop_full;

  always #5 clk = ~clk;

  rx_frame_sequencer #(.DATA_WIDTH(32), .NUM_BUFS(4), .BUF_BYTES(2048)) dut (
    .clk(clk), .rst(rst), .enable(enable), .drop_bad_en(drop_bad_en),
    .drop_when_full(drop_when_full), .rx_frame_ready(rx_frame_ready),
    .rx_len(rx_len), .rx_bad_fcs(rx_bad_fcs), .rxw_data(rxw_data),
    .rxw_valid(rxw_valid), .rxw_pop(rxw_pop), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .buf_release(buf_release),
    .cpl_valid(cpl_valid), .cpl_slot(cpl_slot), .cpl_len(cpl_len),
    .cpl_flags(cpl_flags), .irq(irq), .free_slots(free_slots),
    .cnt_ok(cnt_ok), .cnt_drop_bad(cnt_drop_bad),
    .cnt_drop_full(cnt_drop_full), .err(err));

  // Bridge model: frame queue, word index of the oldest frame.
  int f_len [64];
  bit f_bad [64];
  int tail = 0;
  int head = 0;
  int widx = 0;
  int cyc  = 0;
  int nw_cur;
  assign nw_cur         = (f_len[head % 64] + 3) / 4;
  assign rx_frame_ready = head != tail;
  assign rx_len         = 16'(f_len[head % 64]);
  assign rx_bad_fcs     = f_bad[head % 64];
  assign rxw_valid      = rx_frame_ready && nw_cur > 0;
  assign rxw_data       = {8'(head), 8'hA5, 16'(widx)};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      head <= tail;
      widx <= 0;
    end else if (rxw_pop && rxw_valid) begin
      if (widx + 1 >= nw_cur) begin
        head <= head + 1;
        widx <= 0;
      end else widx <= widx + 1;
    end
  end

  // Monitor
  logic [10:0] wl_addr [4096];
  logic [31:0] wl_data [4096];
  int wl_n = 0, pop_n = 0, cpl_n = 0, irq_bad = 0;
  int cpl_prev_cyc = 0, cpl_last_cyc = 0;
  logic [1:0]  cap_slot;
  logic [15:0] cap_len;
  logic [2:0]  cap_flags;
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wl_addr[wl_n % 4096] <= mem_wr_addr;
      wl_data[wl_n % 4096] <= mem_wr_data;
      wl_n <= wl_n + 1;
    end
    if (rxw_pop) pop_n <= pop_n + 1;
    if (irq !== cpl_valid) irq_bad <= irq_bad + 1;
    if (cpl_valid) begin
      cpl_n        <= cpl_n + 1;
      cap_slot     <= cpl_slot;
      cap_len      <= cpl_len;
      cap_flags    <= cpl_flags;
      cpl_prev_cyc <= cpl_last_cyc;
      cpl_last_cyc <= cyc;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(int len, bit bad);
    f_len[tail % 64] = len;
    f_bad[tail % 64] = bad;
    tail++;
  endtask

  task automatic release_slot();
    @(posedge clk); #1 buf_release = 1'b1;
    @(posedge clk); #1 buf_release = 1'b0;
  endtask

  task automatic wait_cpl(int target, int budget);
    int k = 0;
    while (cpl_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("cpl_seen", cpl_n >= target, 1);
  endtask

  task automatic check_wr(string nm, int start, int n, int base, int id);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (wl_addr[(start + i) % 4096] != 11'(base + i)) bad++;
      if (wl_data[(start + i) % 4096] != {8'(id), 8'hA5, 16'(i)}) bad++;
    end
    check(nm, bad, 0);
  endtask

  typedef struct {
    int len; bit bad; bit dbe;
    int exp_pops; int exp_wr; int exp_base; int exp_slot;
    logic [2:0] exp_flags; int exp_free;
  } vec_t;
  vec_t vt [6];

  initial begin
    int s_wr, s_pop, s_cpl, id, k, p0;
    vt[0] = '{60,   1'b0, 1'b0, 15,  15,  0,    0, 3'b000, 3};
    vt[1] = '{61,   1'b0, 1'b1, 16,  16,  512,  1, 3'b000, 3};
    vt[2] = '{100,  1'b1, 1'b1, 25,  0,   0,    0, 3'b101, 4};
    vt[3] = '{3000, 1'b0, 1'b0, 750, 512, 1024, 2, 3'b010, 3};
    vt[4] = '{5,    1'b1, 1'b0, 2,   2,   1536, 3, 3'b001, 3};
    vt[5] = '{4,    1'b0, 1'b0, 1,   1,   0,    0, 3'b000, 3};

    rst = 1'b1; enable = 1'b1; drop_bad_en = 1'b0; drop_when_full = 1'b0;
    mem_wr_ready = 1'b1; buf_release = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_free", free_slots, 4);
    check("rst_cnt_ok", cnt_ok, 0);
    check("rst_err", err, 0);
    check("rst_cpl", cpl_valid, 0);
    check("rst_pop", rxw_pop, 0);
    check("rst_addr", mem_wr_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      s_wr = wl_n; s_pop = pop_n; s_cpl = cpl_n; id = tail;
      drop_bad_en = vt[i].dbe;
      push(vt[i].len, vt[i].bad);
      wait_cpl(s_cpl + 1, 2000);
      check($sformatf("v%0d_pops", i), pop_n - s_pop, vt[i].exp_pops);
      check($sformatf("v%0d_wrs", i), wl_n - s_wr, vt[i].exp_wr);
      check_wr($sformatf("v%0d_wrdata", i), s_wr, vt[i].exp_wr, vt[i].exp_base, id);
      check($sformatf("v%0d_slot", i), cap_slot, vt[i].exp_slot);
      check($sformatf("v%0d_len", i), cap_len, vt[i].len);
      check($sformatf("v%0d_flags", i), cap_flags, vt[i].exp_flags);
      check($sformatf("v%0d_free", i), free_slots, vt[i].exp_free);
      check($sformatf("v%0d_cpl1cyc", i), cpl_valid, 0);
      if (!vt[i].exp_flags[2]) release_slot();
    end
    drop_bad_en = 1'b0;
    check("cnt_ok_a", cnt_ok, 5);
    check("cnt_bad_a", cnt_drop_bad, 1);

    // Back-to-back 61 and 64 byte frames.
    s_wr = wl_n; s_cpl = cpl_n; id = tail;
    push(61, 1'b0); push(64, 1'b0);
    wait_cpl(s_cpl + 2, 400);
    check("b2b_wrs", wl_n - s_wr, 32);
    check_wr("b2b_wr0", s_wr, 16, 512, id);
    check_wr("b2b_wr1", s_wr + 16, 16, 1024, id + 1);
    check("b2b_gap", (cpl_last_cyc - cpl_prev_cyc) > 1, 1);
    check("b2b_slot", cap_slot, 2);
    check("b2b_free", free_slots, 2);
    release_slot(); release_slot();

    // Fill all slots, then a 5th frame must wait for a release.
    s_cpl = cpl_n;
    for (int i = 0; i < 4; i++) push(8, 1'b0);
    wait_cpl(s_cpl + 4, 200);
    check("full_free0", free_slots, 0);
    s_wr = wl_n; s_pop = pop_n; s_cpl = cpl_n; id = tail;
    push(8, 1'b0);
    repeat (20) @(negedge clk);
    check("full_wait_pops", pop_n - s_pop, 0);
    check("full_wait_cpl", cpl_n - s_cpl, 0);
    check("full_wait_pop", rxw_pop, 0);
    release_slot();
    wait_cpl(s_cpl + 1, 100);
    check("full_rel_slot", cap_slot, 3);
    check_wr("full_rel_wr", s_wr, 2, 1536, id);
    check("full_rel_free", free_slots, 0);
    check("cnt_ok_b", cnt_ok, 12);
    drop_when_full = 1'b1;
    s_wr = wl_n; s_pop = pop_n; s_cpl = cpl_n;
    push(12, 1'b0);
    wait_cpl(s_cpl + 1, 100);
    check("dfull_flags", cap_flags, 3'b100);
    check("dfull_slot", cap_slot, 0);
    check("dfull_pops", pop_n - s_pop, 3);
    check("dfull_wrs", wl_n - s_wr, 0);
    check("dfull_cnt", cnt_drop_full, 1);
    drop_when_full = 1'b0;
    for (int i = 0; i < 4; i++) release_slot();
    check("rel_all_free", free_slots, 4);

    // Write-ready stall in the middle of a 40-word frame.
    s_wr = wl_n; s_pop = pop_n; s_cpl = cpl_n; id = tail;
    push(160, 1'b0);
    k = 0;
    while (pop_n - s_pop < 10 && k < 100) begin @(negedge clk); k++; end
    check("stall_started", pop_n - s_pop >= 10, 1);
    @(posedge clk); #1 mem_wr_ready = 1'b0; p0 = pop_n;
    repeat (3) @(posedge clk);
    #1 check("stall_nopop", pop_n - p0, 0);
    mem_wr_ready = 1'b1;
    wait_cpl(s_cpl + 1, 200);
    check("stall_pops", pop_n - s_pop, 40);
    check("stall_wrs", wl_n - s_wr, 40);
    check_wr("stall_wrdata", s_wr, 40, 0, id);
    check("stall_free", free_slots, 3);
    check("cnt_ok_c", cnt_ok, 13);

    // Release with every slot already free is an error.
    check("err_clear", err, 0);
    release_slot();
    check("rel_free4", free_slots, 4);
    release_slot();
    check("rel_over_err", err, 1);
    check("rel_over_free", free_slots, 4);

    // Reset in the middle of a frame.
    s_pop = pop_n;
    push(200, 1'b0);
    k = 0;
    while (pop_n - s_pop < 5 && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_free", free_slots, 4);
    check("mrst_cnt_ok", cnt_ok, 0);
    check("mrst_err", err, 0);
    check("mrst_wr", mem_wr_en, 0);
    check("mrst_pop", rxw_pop, 0);
    rst = 1'b0;

    // Enable gates new frame starts.
    enable = 1'b0;
    s_wr = wl_n; s_pop = pop_n; s_cpl = cpl_n; id = tail;
    push(8, 1'b0);
    repeat (10) @(negedge clk);
    check("dis_nopop", pop_n - s_pop, 0);
    enable = 1'b1;
    wait_cpl(s_cpl + 1, 100);
    check("en_slot", cap_slot, 0);
    check_wr("en_wr", s_wr, 2, 0, id);

    // Zero-length frame flags an error and is never started.
    s_pop = pop_n; s_cpl = cpl_n;
    push(0, 1'b0);
    repeat (5) @(negedge clk);
    check("zlen_err", err, 1);
    check("zlen_pops", pop_n - s_pop, 0);
    check("zlen_cpl", cpl_n - s_cpl, 0);

    check("irq_eq_cpl", irq_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_frame_sequencer.md
Name: rx_frame_sequencer

Overview:
Controller that drains the RX bridge's MM read window without CPU word-by-word reads. It waits for a queued frame, reads its length and bad-FCS flag, and then either copies the frame into one of NUM_BUFS fixed-size buffer slots in packet RAM or discards it. Each handled frame produces a one-cycle completion record and an IRQ pulse. Sits between the RX AXIS→MM bridge and the packet RAM / CSR block.

Parameters:
DATA_WIDTH, 32, width of rxw_data and mem_wr_data; MM_BYTES = DATA_WIDTH/8.
NUM_BUFS, 4, number of buffer slots; power of two, at least 2.
BUF_BYTES, 2048, bytes per slot; power of two, multiple of MM_BYTES.
Derived: WPS = BUF_BYTES/MM_BYTES (words per slot); WADDR_W = $clog2(NUM_BUFS*WPS); SLOT_W = $clog2(NUM_BUFS).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  sequencer may start new frames
drop_bad_en  in  1  discard frames flagged bad-FCS
drop_when_full  in  1  1 = discard when no free slot; 0 = wait for a slot
rx_frame_ready  in  1  bridge has at least one queued frame
rx_len  in  16  byte length of the oldest frame
rx_bad_fcs  in  1  bad flag of the oldest frame
rxw_data  in  DATA_WIDTH  current read-window word
rxw_valid  in  1  read-window word available
rxw_pop  out  1  consume current word (combinational)
mem_wr_en  out  1  packet RAM write strobe
mem_wr_addr  out  WADDR_W  word address = slot*WPS + word index
mem_wr_data  out  DATA_WIDTH  equals rxw_data
mem_wr_ready  in  1  RAM accepts write this cycle
buf_release  in  1  software frees the oldest in-use slot (1-cycle pulse)
cpl_valid  out  1  1-cycle completion pulse
cpl_slot  out  SLOT_W  slot used (0 when dropped)
cpl_len  out  16  original frame length
cpl_flags  out  3  {dropped, truncated, bad_fcs}
irq  out  1  equals cpl_valid
free_slots  out  SLOT_W+1  number of free slots
cnt_ok, cnt_drop_bad, cnt_drop_full  out  16 each  saturating frame counters
err  out  1  sticky error flag

Behaviour:
- Reset (synchronous): state=IDLE; wr_slot=0; rel_slot=0; free_slots=NUM_BUFS; every other output and counter is 0.
- States: IDLE, COPY, DRAIN, DONE.
- IDLE, entry condition: enable && rx_frame_ready && rx_len!=0. On entry, latch len, bad, and nwords=ceil(len/MM_BYTES); clear word_idx.
  - If bad && drop_bad_en: go to DRAIN, set dropped=1.
  - Else if free_slots==0 && drop_when_full: go to DRAIN, set dropped=1.
  - Else if free_slots==0: stay in IDLE; nothing is latched.
  - Else: go to COPY.
- IDLE, zero length: rx_frame_ready && rx_len==0 sets err; the sequencer stays in IDLE.
- Deasserting enable stops new frame starts only. A frame already in progress always finishes.
- COPY:
  - rxw_pop = mem_wr_en = rxw_valid && mem_wr_ready && word_idx<WPS.
  - When word_idx>=WPS: rxw_pop = rxw_valid, mem_wr_en = 0, truncated=1.
  - Every pop increments word_idx.
  - The pop of word nwords-1 moves to DONE.
  - mem_wr_ready low stalls the pop, and the word is held.
- DRAIN: rxw_pop = rxw_valid. The last pop moves to DONE. No RAM writes.
- DONE, one cycle:
  - Drive cpl_valid=1 and irq=1 with the latched slot, len and flags.
  - Copied frame: wr_slot advances (wraps mod NUM_BUFS), free_slots decrements, cnt_ok increments.
  - Dropped frame: cnt_drop_bad or cnt_drop_full increments (bad takes precedence).
  - Then return to IDLE. DONE gives the bridge one cycle to advance its descriptor before rx_len is re-sampled.
- rxw_pop is never asserted in IDLE or DONE.
- buf_release:
  - Increments free_slots and advances rel_slot, unless free_slots==NUM_BUFS; in that case it sets err and is ignored.
  - Release and DONE in the same cycle: net change to free_slots is 0.
- Counters saturate at 16'hFFFF.
- mem_wr_addr = {wr_slot, word_idx[log2(WPS)-1:0]}.
- Mid-frame reset returns every output to its reset value immediately. The bridge shares rst.

Test Plan:
- DATA_WIDTH=32, one free slot 0, 60-byte good frame -> 15 writes to addr 0..14 with data matching; cpl_len=60, cpl_slot=0, cpl_flags=000, irq for 1 cycle, cnt_ok=1, free_slots=3.
- 61-byte frame, then a 64-byte frame back-to-back -> 16 writes at addr 0..15, then 16 writes at addr 512..527; two cpl pulses separated by at least one IDLE cycle.
- Bad frame of 100 bytes, drop_bad_en=1 -> 25 pops, 0 writes, cpl_flags=101, cnt_drop_bad=1, free_slots unchanged.
- Four frames with no release, 5th frame, drop_when_full=0 -> 5th waits with rxw_pop=0; buf_release -> 5th copied to slot 0 (addr 0..); with drop_when_full=1 instead -> 5th is drained, cnt_drop_full=1.
- 3000-byte frame, BUF_BYTES=2048 -> 512 writes then 238 drain-only pops (750 total); cpl_flags=010, cpl_len=3000.
- mem_wr_ready held low 3 cycles mid-frame -> no pops during the stall, no lost or duplicated words; buf_release with free_slots=4 -> err=1.
